// File: rtl/up_ctrl_regs_if.sv
// Register-bus interface: one-cycle write/read request strobes with registered
// acknowledge pulses and registered read data.
interface up_ctrl_regs_if #(
  parameter int ADDRESS_WIDTH = 8
);
  logic                     up_wreq;
  logic [ADDRESS_WIDTH-1:0] up_waddr;
  logic [31:0]              up_wdata;
  logic                     up_wack;
  logic                     up_rreq;
  logic [ADDRESS_WIDTH-1:0] up_raddr;
  logic [31:0]              up_rdata;
  logic                     up_rack;

  modport master (
    output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    input  up_wack, up_rdata, up_rack
  );

  modport slave (
    input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    output up_wack, up_rdata, up_rack
  );
endinterface

// File: rtl/up_ctrl_regs.sv
// Control/status register block: version, scratch, control, W1C event status
// with maskable level interrupt, and a free-running cycle counter.
module up_ctrl_regs #(
  parameter int          ADDRESS_WIDTH = 8,
  parameter logic [31:0] VERSION       = 32'h0001_0000
) (
  input  logic          up_clk,
  input  logic          up_rst,
  up_ctrl_regs_if.slave bus,
  input  logic [7:0]    evt_in,
  output logic          ctrl_enable,
  output logic          ctrl_soft_rst,
  output logic          irq
);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_VERSION  = ADDRESS_WIDTH'(0);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_SCRATCH  = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_CONTROL  = ADDRESS_WIDTH'(2);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STATUS   = ADDRESS_WIDTH'(3);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_IRQ_MASK = ADDRESS_WIDTH'(4);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_COUNTER  = ADDRESS_WIDTH'(5);

  logic [31:0] scratch;
  logic [31:0] counter;
  logic [7:0]  status;
  logic [7:0]  irq_mask;
  logic [7:0]  status_clr;
  logic [31:0] read_mux;
  logic        wr_scratch;
  logic        wr_control;
  logic        wr_status;
  logic        wr_mask;
  logic        wr_counter;

  always_comb begin
    wr_scratch = bus.up_wreq && (bus.up_waddr == ADDR_SCRATCH);
    wr_control = bus.up_wreq && (bus.up_waddr == ADDR_CONTROL);
    wr_status  = bus.up_wreq && (bus.up_waddr == ADDR_STATUS);
    wr_mask    = bus.up_wreq && (bus.up_waddr == ADDR_IRQ_MASK);
    wr_counter = bus.up_wreq && (bus.up_waddr == ADDR_COUNTER);
    status_clr = wr_status ? bus.up_wdata[7:0] : 8'd0;
  end

  // NOTE: read_mux gets a default before the case so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    read_mux = 32'd0;
    case (bus.up_raddr)
      ADDR_VERSION:  read_mux = VERSION;
      ADDR_SCRATCH:  read_mux = scratch;
      ADDR_CONTROL:  read_mux = {31'd0, ctrl_enable};
      ADDR_STATUS:   read_mux = {24'd0, status};
      ADDR_IRQ_MASK: read_mux = {24'd0, irq_mask};
      ADDR_COUNTER:  read_mux = counter;
      default:       read_mux = 32'd0;
    endcase
  end

  // Reads sample pre-write state, so a same-cycle read and write to one address
  // returns the old value while the write lands on the same edge.
  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      bus.up_wack   <= 1'b0;
      bus.up_rack   <= 1'b0;
      bus.up_rdata  <= 32'd0;
      scratch       <= 32'd0;
      ctrl_enable   <= 1'b0;
      ctrl_soft_rst <= 1'b0;
      status        <= 8'd0;
      irq_mask      <= 8'hFF;
      counter       <= 32'd0;
      irq           <= 1'b0;
    end else begin
      bus.up_wack   <= bus.up_wreq;
      bus.up_rack   <= bus.up_rreq;
      bus.up_rdata  <= bus.up_rreq ? read_mux : 32'd0;
      if (wr_scratch) scratch <= bus.up_wdata;
      if (wr_control) ctrl_enable <= bus.up_wdata[0];
      ctrl_soft_rst <= wr_control && bus.up_wdata[1];
      // Clear first, then OR in new events so a same-cycle event beats the W1C.
      status        <= (status & ~status_clr) | evt_in;
      if (wr_mask) irq_mask <= bus.up_wdata[7:0];
      if (wr_counter)       counter <= 32'd0;
      else if (ctrl_enable) counter <= counter + 32'd1;
      irq           <= |(status & ~irq_mask);
    end
  end
endmodule

// File: tb/tb_up_ctrl_regs.sv
// Self-checking bench for up_ctrl_regs: directed scenarios plus randomized
// traffic compared against a register-map model kept in the bench.
module tb_up_ctrl_regs;
  localparam int          AW  = 8;
  localparam logic [31:0] VER = 32'h0001_0000;

  logic       up_clk = 1'b0;
  logic       up_rst;
  logic [7:0] evt_in;
  logic       ctrl_enable;
  logic       ctrl_soft_rst;
  logic       irq;

  up_ctrl_regs_if #(.ADDRESS_WIDTH(AW)) bus ();

  up_ctrl_regs #(.ADDRESS_WIDTH(AW), .VERSION(VER)) dut (
    .up_clk        (up_clk),
    .up_rst        (up_rst),
    .bus           (bus),
    .evt_in        (evt_in),
    .ctrl_enable   (ctrl_enable),
    .ctrl_soft_rst (ctrl_soft_rst),
    .irq           (irq)
  );

  always #5 up_clk = ~up_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Register-map model and the outputs it predicts for the cycle just stepped.
  logic [31:0] m_scratch, m_counter;
  logic        m_en;
  logic [7:0]  m_status, m_mask;
  logic        e_wack, e_rack, e_soft, e_irq;
  logic [31:0] e_rdata;

  task automatic model_reset();
    m_scratch = 32'd0; m_counter = 32'd0; m_en = 1'b0;
    m_status  = 8'd0;  m_mask    = 8'hFF;
    e_wack = 1'b0; e_rack = 1'b0; e_soft = 1'b0; e_irq = 1'b0; e_rdata = 32'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    case (a)
      8'h00:   return VER;
      8'h01:   return m_scratch;
      8'h02:   return {31'd0, m_en};
      8'h03:   return {24'd0, m_status};
      8'h04:   return {24'd0, m_mask};
      8'h05:   return m_counter;
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle();
    bus.up_wreq = 1'b0; bus.up_rreq = 1'b0; evt_in = 8'd0;
    bus.up_waddr = '0; bus.up_raddr = '0; bus.up_wdata = 32'd0;
  endtask

  task automatic drive_wr(input logic [AW-1:0] a, input logic [31:0] d);
    bus.up_wreq = 1'b1; bus.up_waddr = a; bus.up_wdata = d;
  endtask

  task automatic drive_rd(input logic [AW-1:0] a);
    bus.up_rreq = 1'b1; bus.up_raddr = a;
  endtask

  // Advance one clock with the currently driven inputs; predict outputs, then
  // land on the falling edge with all strobes cleared.
  task automatic step();
    logic [31:0] next_counter;
    logic [7:0]  clr;
    e_wack  = bus.up_wreq;
    e_rack  = bus.up_rreq;
    e_rdata = bus.up_rreq ? model_read(bus.up_raddr) : 32'd0;
    e_irq   = (m_status & ~m_mask) != 8'd0;
    e_soft  = 1'b0;
    next_counter = m_en ? m_counter + 32'd1 : m_counter;
    clr = 8'd0;
    if (bus.up_wreq) begin
      case (bus.up_waddr)
        8'h01: m_scratch = bus.up_wdata;
        8'h02: begin m_en = bus.up_wdata[0]; e_soft = bus.up_wdata[1]; end
        8'h03: clr = bus.up_wdata[7:0];
        8'h04: m_mask = bus.up_wdata[7:0];
        8'h05: next_counter = 32'd0;
        default: ;
      endcase
    end
    m_status  = (m_status & ~clr) | evt_in;
    m_counter = next_counter;
    @(posedge up_clk);
    @(negedge up_clk);
    idle();
  endtask

  task automatic test_reset();
    up_rst = 1'b1;
    idle();
    model_reset();
    repeat (3) @(negedge up_clk);
    n_checks++;
    if ({bus.up_wack, bus.up_rack, bus.up_rdata} !== 34'd0) begin
      n_fail++; $display("FAIL reset_bus: got %h, expected 0", {bus.up_wack, bus.up_rack, bus.up_rdata});
    end
    n_checks++;
    if ({ctrl_enable, ctrl_soft_rst, irq} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, expected 000", {ctrl_enable, ctrl_soft_rst, irq});
    end
    up_rst = 1'b0;
  endtask

  task automatic test_reads();
    logic [AW-1:0] addrs [7] = '{8'h00, 8'h01, 8'h3F, 8'h04, 8'h02, 8'h03, 8'h05};
    logic [31:0]   want  [7] = '{VER, 32'd0, 32'd0, 32'h0000_00FF, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 7; i++) begin
      drive_rd(addrs[i]);
      step();
      n_checks++;
      if ({bus.up_rack, bus.up_rdata} !== {1'b1, want[i]}) begin
        n_fail++; $display("FAIL read_after_reset[%h]: got ack=%b data=%h, expected ack=1 data=%h",
                           addrs[i], bus.up_rack, bus.up_rdata, want[i]);
      end
      step();
      n_checks++;
      if ({bus.up_rack, bus.up_rdata} !== 33'd0) begin
        n_fail++; $display("FAIL read_idle[%h]: got ack=%b data=%h, expected 0", addrs[i], bus.up_rack, bus.up_rdata);
      end
    end
  endtask

  task automatic test_scratch();
    drive_wr(8'h01, 32'hA5A5_5A5A);
    step();
    n_checks++;
    if (bus.up_wack !== 1'b1) begin n_fail++; $display("FAIL scratch_wack: got %b, expected 1", bus.up_wack); end
    step();
    n_checks++;
    if (bus.up_wack !== 1'b0) begin n_fail++; $display("FAIL wack_one_cycle: got %b, expected 0", bus.up_wack); end
    drive_rd(8'h01);
    step();
    n_checks++;
    if (bus.up_rdata !== 32'hA5A5_5A5A) begin
      n_fail++; $display("FAIL scratch_read: got %h, expected a5a55a5a", bus.up_rdata);
    end
    drive_wr(8'h3F, 32'd1);
    step();
    n_checks++;
    if (bus.up_wack !== 1'b1) begin n_fail++; $display("FAIL undecoded_wack: got %b, expected 1", bus.up_wack); end
    drive_rd(8'h3F);
    step();
    n_checks++;
    if ({bus.up_rack, bus.up_rdata} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL undecoded_read: got ack=%b data=%h, expected ack=1 data=0", bus.up_rack, bus.up_rdata);
    end
    drive_rd(8'h01);
    step();
    n_checks++;
    if (bus.up_rdata !== 32'hA5A5_5A5A) begin
      n_fail++; $display("FAIL scratch_untouched: got %h, expected a5a55a5a", bus.up_rdata);
    end
  endtask

  task automatic test_status_irq();
    drive_wr(8'h04, 32'h0000_00FE);
    step();
    evt_in = 8'h05;
    step();
    step();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_raise: got %b, expected 1", irq); end
    drive_rd(8'h03);
    step();
    n_checks++;
    if (bus.up_rdata !== 32'h0000_0005) begin n_fail++; $display("FAIL status_set: got %h, expected 5", bus.up_rdata); end
    drive_wr(8'h03, 32'h0000_0001);
    step();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_lag: got %b, expected 1", irq); end
    step();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b, expected 0", irq); end
    drive_rd(8'h03);
    step();
    n_checks++;
    if (bus.up_rdata !== 32'h0000_0004) begin n_fail++; $display("FAIL status_w1c: got %h, expected 4", bus.up_rdata); end
  endtask

  task automatic test_w1c_collision();
    drive_wr(8'h03, 32'h0000_00FF);
    step();
    drive_wr(8'h03, 32'h0000_0004);
    evt_in = 8'h04;
    step();
    drive_rd(8'h03);
    step();
    n_checks++;
    if (bus.up_rdata !== 32'h0000_0004) begin n_fail++; $display("FAIL set_beats_clear: got %h, expected 4", bus.up_rdata); end
  endtask

  task automatic test_control_counter();
    logic [31:0] r0, r1;
    drive_wr(8'h02, 32'd3);
    step();
    n_checks++;
    if ({ctrl_soft_rst, ctrl_enable} !== 2'b11) begin
      n_fail++; $display("FAIL control_write: got soft/en=%b, expected 11", {ctrl_soft_rst, ctrl_enable});
    end
    drive_rd(8'h02);
    step();
    n_checks++;
    if ({ctrl_soft_rst, bus.up_rdata} !== {1'b0, 32'd1}) begin
      n_fail++; $display("FAIL control_read: got soft=%b data=%h, expected soft=0 data=1", ctrl_soft_rst, bus.up_rdata);
    end
    drive_rd(8'h05);
    step();
    r0 = bus.up_rdata;
    n_checks++;
    if (r0 !== e_rdata) begin n_fail++; $display("FAIL counter_read0: got %h, expected %h", r0, e_rdata); end
    repeat (10) step();
    drive_rd(8'h05);
    step();
    r1 = bus.up_rdata;
    n_checks++;
    if (r1 - r0 !== 32'd11) begin n_fail++; $display("FAIL counter_advance: got delta %0d, expected 11", r1 - r0); end
    drive_wr(8'h05, $urandom | 32'h1);
    step();
    drive_rd(8'h05);
    step();
    n_checks++;
    if (bus.up_rdata !== 32'd0) begin n_fail++; $display("FAIL counter_clear: got %h, expected 0", bus.up_rdata); end
    drive_rd(8'h05);
    step();
    n_checks++;
    if (bus.up_rdata !== 32'd1) begin n_fail++; $display("FAIL counter_after_clear: got %h, expected 1", bus.up_rdata); end
  endtask

  task automatic test_simul_rw();
    logic [31:0] d;
    d = $urandom;
    drive_wr(8'h01, d);
    drive_rd(8'h01);
    step();
    n_checks++;
    if ({bus.up_wack, bus.up_rack, bus.up_rdata} !== {2'b11, e_rdata}) begin
      n_fail++; $display("FAIL simul_rw: got wack=%b rack=%b data=%h, expected 1 1 %h",
                         bus.up_wack, bus.up_rack, bus.up_rdata, e_rdata);
    end
    drive_rd(8'h01);
    step();
    n_checks++;
    if (bus.up_rdata !== d) begin n_fail++; $display("FAIL simul_rw_after: got %h, expected %h", bus.up_rdata, d); end
  endtask

  task automatic test_back_to_back();
    logic [36:0] got, exp;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) drive_wr(($urandom_range(0, 9) == 9) ? 8'h3F : AW'($urandom_range(0, 6)), $urandom);
      if ($urandom_range(0, 1) == 1) drive_rd(($urandom_range(0, 9) == 9) ? 8'h3F : AW'($urandom_range(0, 6)));
      evt_in = 8'($urandom & $urandom & $urandom);
      step();
      got = {bus.up_wack, bus.up_rack, bus.up_rdata, ctrl_soft_rst, ctrl_enable, irq};
      exp = {e_wack, e_rack, e_rdata, e_soft, m_en, e_irq};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL random_cycle %0d: got {wack,rack,rdata,soft,en,irq}=%h, expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_wrap();
    drive_wr(8'h02, 32'd1);
    step();
    force dut.counter = 32'hFFFF_FFFE;
    #1;
    release dut.counter;
    m_counter = 32'hFFFF_FFFE;
    step();
    n_checks++;
    if (dut.counter !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL counter_max: got %h, expected ffffffff", dut.counter); end
    drive_rd(8'h05);
    step();
    n_checks++;
    if ({dut.counter, bus.up_rdata} !== {32'd0, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL counter_wrap: got count=%h read=%h, expected 0 ffffffff", dut.counter, bus.up_rdata);
    end
  endtask

  task automatic test_reset_mid();
    drive_rd(8'h00);
    drive_wr(8'h01, 32'hDEAD_BEEF);
    #2;
    up_rst = 1'b1;
    @(posedge up_clk);
    @(negedge up_clk);
    n_checks++;
    if ({bus.up_wack, bus.up_rack, bus.up_rdata, ctrl_enable, ctrl_soft_rst, irq} !== 37'd0) begin
      n_fail++; $display("FAIL reset_mid: got wack=%b rack=%b data=%h en=%b soft=%b irq=%b, expected all 0",
                         bus.up_wack, bus.up_rack, bus.up_rdata, ctrl_enable, ctrl_soft_rst, irq);
    end
    idle();
    @(negedge up_clk);
    up_rst = 1'b0;
    model_reset();
    drive_rd(8'h04);
    step();
    n_checks++;
    if ({bus.up_rack, bus.up_rdata} !== {1'b1, 32'h0000_00FF}) begin
      n_fail++; $display("FAIL first_after_reset: got ack=%b data=%h, expected ack=1 data=ff", bus.up_rack, bus.up_rdata);
    end
    drive_rd(8'h01);
    step();
    n_checks++;
    if (bus.up_rdata !== 32'd0) begin n_fail++; $display("FAIL aborted_write: got %h, expected 0", bus.up_rdata); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_reads();
    test_scratch();
    test_status_irq();
    test_w1c_collision();
    test_control_counter();
    test_simul_rw();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
